// File: rtl/alu181_serial.sv
// alu181_serial: digit-serial 74181-style ALU, one 4-bit slice per clock, LSB slice first.
module alu181_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             eq,
  output logic             zero,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  // DONE is encoded in bit 1 alone so out_valid comes straight off a flop
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] ra, rb, acc, res_n;
  logic [3:0]       rs, sa, sb, x, y, slice;
  logic [4:0]       sum;
  logic [KW-1:0]    k;
  logic             rm, carry, c3, last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = in_valid ? BUSY : IDLE;
      BUSY: nxt = last ? DONE : BUSY;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state[1];
  end
  // Operands shift right each slice so the active slice is always bits [3:0]
  always_comb begin
    sa    = ra[3:0];
    sb    = rb[3:0];
    x     = sa | (rs[0] ? sb : 4'h0) | (rs[1] ? ~sb : 4'h0);
    y     = (rs[2] ? sa & ~sb : 4'h0) | (rs[3] ? sa & sb : 4'h0);
    sum   = {1'b0, x} + {1'b0, y} + {4'h0, carry};
    c3    = x[3] ^ y[3] ^ sum[3];
    slice = rm ? ~(x ^ y) : sum[3:0];
    res_n = WIDTH'({slice, acc} >> 4);
    last  = k == KW'(N - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0; rb <= '0; acc <= '0; rs <= '0; rm <= 1'b0; carry <= 1'b0; k <= '0;
      f <= '0; cout <= 1'b0; eq <= 1'b0; zero <= 1'b0; ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra <= a; rb <= b; rs <= s; rm <= m; carry <= cin & ~m; k <= '0;
    end else if (state == BUSY) begin
      ra    <= ra >> 4;
      rb    <= rb >> 4;
      acc   <= res_n;
      carry <= sum[4];
      k     <= k + KW'(1);
      if (last) begin
        f    <= res_n;
        cout <= ~rm & sum[4];
        ovf  <= ~rm & (c3 ^ sum[4]);
        eq   <= &res_n;
        zero <= ~|res_n;
      end
    end
endmodule

// File: tb/tb_alu181_serial.sv
// tb_alu181_serial: directed checks of alu181_serial at WIDTH=16 plus an (s,m) sweep at 4/16/32.
module tb_alu181_serial;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iv = 1'b0, or_ = 1'b0, iv2 = 1'b0, or2 = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0] s = '0;
  logic m = 1'b0, cin = 1'b0;
  logic ir16, ov16, co16, eq16, z16, vf16;
  logic [15:0] f16;
  logic ir4, ov4, co4, eq4, z4, vf4;
  logic [3:0] f4;
  logic ir32, ov32, co32, eq32, z32, vf32;
  logic [31:0] f32;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu181_serial #(.WIDTH(16)) d16 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .s(s), .m(m), .cin(cin), .out_valid(ov16), .out_ready(or_),
    .f(f16), .cout(co16), .eq(eq16), .zero(z16), .ovf(vf16));
  alu181_serial #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir4),
    .a(a[3:0]), .b(b[3:0]), .s(s), .m(m), .cin(cin), .out_valid(ov4), .out_ready(or2),
    .f(f4), .cout(co4), .eq(eq4), .zero(z4), .ovf(vf4));
  alu181_serial #(.WIDTH(32)) d32 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir32),
    .a(a), .b(b), .s(s), .m(m), .cin(cin), .out_valid(ov32), .out_ready(or2),
    .f(f32), .cout(co32), .eq(eq32), .zero(z32), .ovf(vf32));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] ref_op(input logic [31:0] av, input logic [31:0] bv,
      input logic [3:0] sv, input logic mv, input logic cv, input int w);
    logic [63:0] mask, hm, x, y, sum, fr, cm;
    logic co, vo;
    mask = (64'h1 << w) - 64'h1;
    hm   = mask >> 1;
    x = ({32'h0, av} | (sv[0] ? {32'h0, bv} : 64'h0) | (sv[1] ? ~{32'h0, bv} : 64'h0)) & mask;
    y = ((sv[2] ? {32'h0, av & ~bv} : 64'h0) | (sv[3] ? {32'h0, av & bv} : 64'h0)) & mask;
    if (mv) begin
      fr = ~(x ^ y) & mask; co = 1'b0; vo = 1'b0;
    end else begin
      sum = x + y + {63'h0, cv};
      fr  = sum & mask;
      co  = sum[w];
      cm  = ((x & hm) + (y & hm) + {63'h0, cv}) >> (w - 1);
      vo  = cm[0] ^ co;
    end
    return {co, vo, fr == mask, fr == 64'h0, fr[31:0]};
  endfunction

  function automatic logic [63:0] pk16;
    return {44'h0, co16, vf16, eq16, z16, f16};
  endfunction

  task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
      input logic [3:0] sv, input logic mv, input logic cv);
    int lat;
    a = {16'h0, av}; b = {16'h0, bv}; s = sv; m = mv; cin = cv; iv = 1'b1;
    tick;
    iv = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      tick;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic consume16;
    or_ = 1'b1;
    tick;
    or_ = 1'b0;
    chk("consume_in_ready", {63'h0, ir16}, 64'd1);
  endtask

  task automatic run_aux(input int code);
    int t;
    logic [35:0] e4, e32;
    iv2 = 1'b1;
    tick;
    iv2 = 1'b0;
    t = 0;
    while (!(ov4 && ov32) && t < 20) begin
      tick;
      t++;
    end
    chk("aux_done", {63'h0, ov4 && ov32}, 64'd1);
    e4  = ref_op(a, b, s, m, cin, 4);
    e32 = ref_op(a, b, s, m, cin, 32);
    chk($sformatf("w4_code%0d", code), {28'h0, co4, vf4, eq4, z4, 28'h0, f4}, {28'h0, e4});
    chk($sformatf("w32_code%0d", code), {28'h0, co32, vf32, eq32, z32, f32}, {28'h0, e32});
    or2 = 1'b1;
    tick;
    or2 = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_outputs", {58'h0, ir16, ov16, co16, eq16, z16, vf16}, {58'h0, 6'b100000});
    chk("reset_f", {48'h0, f16}, 64'h0);
    tick;
    rst_n = 1'b1;
    chk("reset_idle", {62'h0, ir16, ov16}, 64'b10);

    run16("add", 16'h1234, 16'h0FFF, 4'd9, 1'b0, 1'b0);
    chk("add_res", pk16(), {44'h0, 4'b0000, 16'h2233});
    consume16;
    run16("wrap", 16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0);
    chk("wrap_res", pk16(), {44'h0, 4'b1001, 16'h0000});
    consume16;
    run16("ovf", 16'h7FFF, 16'h0001, 4'd9, 1'b0, 1'b0);
    chk("ovf_res", pk16(), {44'h0, 4'b0100, 16'h8000});
    consume16;
    run16("cmp0", 16'h5A5A, 16'h5A5A, 4'd6, 1'b0, 1'b0);
    chk("cmp0_res", pk16(), {44'h0, 4'b0010, 16'hFFFF});
    consume16;
    run16("cmp1", 16'h5A5A, 16'h5A5A, 4'd6, 1'b0, 1'b1);
    chk("cmp1_res", pk16(), {44'h0, 4'b1001, 16'h0000});
    consume16;
    run16("logic", 16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b1);
    chk("logic_res", pk16(), {44'h0, 4'b0000, 16'h0FF0});
    consume16;

    run16("bp", 16'h0001, 16'h0002, 4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = 32'($urandom); b = 32'($urandom); iv = i[0];
      tick;
      chk("bp_hold", pk16(), {44'h0, 4'b0000, 16'h0003});
      chk("bp_hs", {62'h0, ir16, ov16}, 64'b01);
    end
    iv = 1'b0;
    or_ = 1'b1;
    tick;
    or_ = 1'b0;
    chk("bp_release", {62'h0, ir16, ov16}, 64'b10);
    chk("bp_keep_f", pk16(), {44'h0, 4'b0000, 16'h0003});

    a = 32'h0000_1111; b = 32'h0000_2222; s = 4'd9; m = 1'b0; cin = 1'b0; iv = 1'b1;
    tick;
    iv = 1'b0;
    tick;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {58'h0, ir16, ov16, co16, eq16, z16, vf16}, {58'h0, 6'b100000});
    chk("abort_f", {48'h0, f16}, 64'h0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_valid", {63'h0, ov16}, 64'd0);
    end
    run16("after_rst", 16'h1111, 16'h2222, 4'd9, 1'b0, 1'b1);
    chk("after_rst_res", pk16(), {44'h0, 4'b0000, 16'h3334});
    consume16;

    for (int c = 0; c < 32; c++) begin
      logic [35:0] e16;
      logic [15:0] ra, rb;
      logic rc;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      run16("sweep16", ra, rb, 4'(c), c[4], rc);
      e16 = ref_op({16'h0, ra}, {16'h0, rb}, 4'(c), c[4], rc, 16);
      chk($sformatf("w16_code%0d", c), pk16(), {44'h0, e16[35:32], e16[15:0]});
      consume16;
      a = 32'($urandom); b = 32'($urandom); cin = 1'($urandom);
      run_aux(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu181_serial.md
# alu181_serial

Digit-serial, parametrised-width ALU that implements the full 16-function logic and 16-function arithmetic set of the 4-bit 74181-style ALU over WIDTH bits. It processes one 4-bit slice per clock, LSB slice first, and keeps the inter-slice carry in a register. Operands are accepted and results returned over valid/ready handshakes. The block is the datapath ALU for the multi-cycle lab CPU, where area matters more than single-cycle latency.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; N = WIDTH/4 slices.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- a, b  in  WIDTH  operands; active-high data.
- s  in  4  function select.
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- cin  in  1  carry in; active-high, so 1 adds one. Ignored when m=1.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer accepts the result.
- f  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1; 0 when m=1.
- eq  out  1  f is all ones. This is the A=B indication when s=6, m=0, cin=0.
- zero  out  1  f == 0.
- ovf  out  1  signed overflow, equal to carry into the MSB xor cout; 0 when m=1.

## Operation
- Function definition, applied bitwise on latched operands:
  - X = A | (s[0] ? B : 0) | (s[1] ? ~B : 0)
  - Y = (s[2] ? A&~B : 0) | (s[3] ? A&B : 0)
  - Logic mode: F = ~(X ^ Y).
  - Arithmetic mode: F = X + Y + cin, modulo 2^WIDTH.
- Examples: s=9 gives A+B / XNOR; s=6 gives A−B−1+cin / XOR; s=0 gives A / ~A; s=15 gives A−1+cin / A.
- The slice result must equal the full-width definition above for every WIDTH.
- States are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b, s, m, cin; clear the slice index; load the carry register with cin (0 when m=1); go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle computes slice k (bits 4k+3..4k) from the latched operands and the carry register, writes it into the result shift/accumulate register, updates the carry and increments k.
  - After slice N−1 is computed: load f, cout, eq, zero, ovf; set out_valid=1; go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - f and all flags are held stable until out_valid && out_ready, then go to IDLE.
- Changes on a/b/s/m/cin after acceptance have no effect on the operation in flight.
- After consumption, f and the flags keep their last values while out_valid=0.
- The carry chain runs through all slices in logic mode too, but cout and ovf are forced to 0 in that mode.

## Timing
- Reset values:
  - State IDLE, in_ready=1, out_valid=0.
  - f=0, cout=0, eq=0, zero=0, ovf=0.
  - Internal carry and slice index 0.
- Reset asserted in any state, including mid-BUSY, aborts immediately. No result is produced for the aborted operation.
- The first rising edge after rst_n deasserts may accept a request.
- Latency: if acceptance occurs at edge t, out_valid rises after edge t+N.
  - WIDTH=4 gives 1 cycle; WIDTH=16 gives 4 cycles.
- Throughput: at best one operation per N+2 cycles, made up of the accept edge, N BUSY edges and the consume edge; the next accept comes one edge after consumption.
- in_ready is a pure function of the state, with no combinational path from in_valid.
- out_valid is registered; out_ready back-pressure may hold DONE indefinitely.

## Test plan
- WIDTH=16, m=0, s=9, cin=0, a=0x1234, b=0x0FFF -> f=0x2233, cout=0, zero=0, ovf=0. out_valid rises exactly 4 cycles after acceptance.
- Add wrap: s=9, cin=0, a=0xFFFF, b=0x0001 -> f=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001 -> f=0x8000, cout=0, ovf=1.
- Compare: s=6, m=0, cin=0, a=b=0x5A5A -> f=0xFFFF, eq=1, cout=0. The same operands with cin=1 give f=0x0000, cout=1, zero=1.
- Logic: m=1, s=6, cin=1, a=0xF0F0, b=0xFF00 -> f=0x0FF0, cout=0, ovf=0. Sweep all 32 (s,m) codes with random operands against the X/Y reference model at WIDTH=4, 16 and 32.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while changing a/b and pulsing in_valid. Required: f and the flags stay stable, in_ready=0, and nothing is accepted. Releasing out_ready gives IDLE on the next edge.
- Reset mid-BUSY at slice 2 of 4 -> all outputs return to reset values asynchronously and out_valid never asserts for the aborted operation. A new request after reset completes correctly.
